dice_scorer: RTL
================

Name: dice_scorer

Overview:
- Consumer end of the electronic dice interface: watches the same button and the dice's throw[2:0] output.
- On each button release, captures the settled throw and validates it (1..6).
- Accumulates a game score and counts rolls; detects doubles (two equal consecutive valid throws).
- Drives a 7-LED pip face. Ends the game after MAX_ROLLS valid rolls; new_game restarts it.

Parameters:
MAX_ROLLS, 10, valid rolls per game; must be >= 1 and < 2**ROLL_W
ROLL_W, 4, width of the roll counter
SCORE_W, 8, width of the score accumulator; saturates at 2**SCORE_W-1

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  reset, synchronous, active-high
button  in  1  roll button, same signal that drives the dice; high = rolling
throw  in  3  dice value; legal 1..6, updates only while button=1
new_game  in  1  synchronous game restart, single-cycle or level
score  out  SCORE_W  sum of valid captured throws this game
rolls  out  ROLL_W  number of valid captures this game
last  out  3  most recent valid captured throw; 0 = none yet
pips  out  7  die face [0]TL [1]TR [2]ML [3]C [4]MR [5]BL [6]BR, 1 = lit
roll_valid  out  1  one-cycle pulse on each valid capture
bad_throw  out  1  one-cycle pulse on capture of 0 or 7
double_flag  out  1  high after a valid capture equal to the previous valid capture; held until next valid capture
game_over  out  1  high while in OVER

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; score=0, rolls=0, last=0, button_q=0, double_flag=0; roll_valid=0, bad_throw=0. game_over=0 and pips=7'h00 follow from state and last. rst overrides all inputs.
- button_q is button registered each cycle. release = button_q=1 and button=0.
- throw is final at release: the dice holds its value when it samples button=0.
- States:
  - IDLE -> ROLLING when button=1.
  - ROLLING -> IDLE on release; the capture happens at that same edge.
  - IDLE -> OVER registered one cycle after the capture that makes rolls reach MAX_ROLLS.
  - OVER -> IDLE only via new_game.
- Capture at the release edge, valid case (throw 1..6):
  - score <= min(score+throw, 2**SCORE_W-1); operand zero-extended.
  - rolls <= rolls+1; last <= throw.
  - double_flag <= (rolls!=0 && throw==last).
  - roll_valid pulses the next cycle (registered, 1-cycle latency).
- Capture at the release edge, invalid case (throw 0 or 7):
  - score, rolls, last and double_flag unchanged.
  - bad_throw pulses 1 cycle; the roll does not count.
- OVER: button and release ignored, no captures. score, rolls and last frozen; game_over=1.
- new_game=1 at an edge (not reset):
  - Same effect as reset on all registers except button_q.
  - Priority over a simultaneous release: that capture is discarded.
  - If button=1 in that cycle, next state is ROLLING; otherwise IDLE.
- pips, combinational from registered state:
  - ROLLING: decode of live throw (animation).
  - Otherwise: decode of last.
  - Decode: 1=7'h08, 2=7'h41, 3=7'h49, 4=7'h63, 5=7'h6B, 6=7'h77, 0 or 7 = 7'h00.
- Button held across reset: after reset the bench sees IDLE->ROLLING next edge. A release only counts if button_q=1 was registered after reset.
- No wrap of rolls: MAX_ROLLS < 2**ROLL_W and OVER blocks further increments.

Decomposition:
- Package dice_pkg:
  - state enum {IDLE, ROLLING, OVER}
  - pip constants PIP_1..PIP_6, PIP_OFF
  - THROW_MIN=1, THROW_MAX=6
  - function is_legal_throw
- Sub-module dice_pips: combinational 3-bit value -> 7-bit face decoder. Instantiated once; also reusable by the team's display blocks.

Test Plan:
- Reset, then press 3 cycles and release with throw=4 -> next cycle roll_valid=1, score=4, rolls=1, last=4, pips=7'h63, double_flag=0.
- Two consecutive releases with throw=5 then 5 -> score=10, rolls=2, double_flag=1. Third release with throw=2 -> double_flag=0, score=12.
- Force throw=7 at release -> bad_throw pulse; score, rolls and last unchanged; pips still shows previous last.
- MAX_ROLLS=10 with all throws 6 -> after 10th capture score=60, rolls=10, game_over=1. A further press/release changes nothing. new_game -> all zero, IDLE.
- SCORE_W=4, throws 6,6,6 -> score saturates at 15, not wrapped.
- new_game asserted on the same edge as a release with throw=3 -> score=0, rolls=0, no roll_valid. Later rst asserted mid-ROLLING -> IDLE with all outputs zero.

Source files
------------

// File: rtl/dice_pkg.sv
// dice_pkg: shared types and constants for the dice consumer blocks.
//   dice_state_e   : scorer FSM states (IDLE, ROLLING, OVER)
//   PIP_1..PIP_6   : 7-LED face patterns, bit order
//                    [0]TL [1]TR [2]ML [3]C [4]MR [5]BL [6]BR, 1 = lit
//   PIP_OFF        : blank face, shown for "no value" and illegal codes
//   THROW_MIN/MAX  : legal dice value range
//   is_legal_throw : 1 when a 3-bit dice value lies in THROW_MIN..THROW_MAX
package dice_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROLLING = 2'd1,
    OVER    = 2'd2
  } dice_state_e;

  localparam logic [6:0] PIP_OFF = 7'h00;
  localparam logic [6:0] PIP_1   = 7'h08;
  localparam logic [6:0] PIP_2   = 7'h41;
  localparam logic [6:0] PIP_3   = 7'h49;
  localparam logic [6:0] PIP_4   = 7'h63;
  localparam logic [6:0] PIP_5   = 7'h6B;
  localparam logic [6:0] PIP_6   = 7'h77;

  localparam logic [2:0] THROW_MIN = 3'd1;
  localparam logic [2:0] THROW_MAX = 3'd6;

  function automatic logic is_legal_throw(input logic [2:0] t);
    return (t >= THROW_MIN) && (t <= THROW_MAX);
  endfunction

endpackage

// File: rtl/dice_pips.sv
// dice_pips: combinational decoder from a 3-bit dice value to a 7-LED face.
//   value : dice value; 1..6 light the matching face, 0 and 7 blank it
//   pips  : [0]TL [1]TR [2]ML [3]C [4]MR [5]BL [6]BR, 1 = lit
import dice_pkg::*;

module dice_pips (
  input  logic [2:0] value,
  output logic [6:0] pips
);

  always_comb begin
    pips = PIP_OFF;
    case (value)
      3'd1:    pips = PIP_1;
      3'd2:    pips = PIP_2;
      3'd3:    pips = PIP_3;
      3'd4:    pips = PIP_4;
      3'd5:    pips = PIP_5;
      3'd6:    pips = PIP_6;
      default: pips = PIP_OFF;
    endcase
  end

endmodule

// File: rtl/dice_scorer.sv
// dice_scorer: consumer end of the electronic dice. Watches the roll button
// and the dice value, captures the settled value on every button release,
// accumulates a saturating score, counts valid rolls, flags doubles and
// drives a pip face. The game ends after MAX_ROLLS valid rolls; new_game
// restarts it.
//
// Ports:
//   clk, rst      : clock (rising edge), synchronous active-high reset
//   button        : roll button, high while the dice is rolling
//   throw         : dice value, final at the release edge
//   new_game      : synchronous game restart (pulse or level)
//   score         : saturating sum of valid captured throws
//   rolls         : number of valid captures this game
//   last          : most recent valid throw, 0 = none yet
//   pips          : face of the live throw while rolling, else of last
//   roll_valid    : 1-cycle pulse after each valid capture
//   bad_throw     : 1-cycle pulse after a capture of 0 or 7
//   double_flag   : last valid capture equalled the one before it
//   game_over     : high while the game is over
//   state_dbg     : current FSM state (dice_state_e encoding)
//
// Handshake: there is no ready/valid pair here. A capture is the single
// event "state is ROLLING and button falls" (button_q=1, button=0); its
// result is visible one cycle later together with roll_valid or bad_throw.
import dice_pkg::*;

module dice_scorer #(
  parameter int MAX_ROLLS = 10,
  parameter int ROLL_W    = 4,
  parameter int SCORE_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               button,
  input  logic [2:0]         throw,
  input  logic               new_game,
  output logic [SCORE_W-1:0] score,
  output logic [ROLL_W-1:0]  rolls,
  output logic [2:0]         last,
  output logic [6:0]         pips,
  output logic               roll_valid,
  output logic               bad_throw,
  output logic               double_flag,
  output logic               game_over,
  output logic [1:0]         state_dbg
);

  localparam logic [ROLL_W-1:0] MAX_R = ROLL_W'(MAX_ROLLS);

  dice_state_e state, state_nxt;
  logic        button_q;
  logic        release_ev;
  logic        capture;
  logic        legal;
  logic        take_valid;
  logic        take_bad;
  logic [SCORE_W:0]   sum_ext;
  logic [SCORE_W-1:0] score_sat;
  logic [2:0]  face_val;

  // A release only counts while ROLLING; button_q is cleared by reset so a
  // button held through reset cannot produce a spurious release.
  assign release_ev = button_q & ~button;
  assign capture    = (state == ROLLING) & release_ev;
  assign legal      = is_legal_throw(throw);

  // new_game wins over a simultaneous release: that capture is dropped.
  assign take_valid = capture & legal  & ~new_game;
  assign take_bad   = capture & ~legal & ~new_game;

  // One extra bit catches the carry; on carry the score pins at all-ones.
  assign sum_ext   = {1'b0, score} + (SCORE_W+1)'(throw);
  assign score_sat = sum_ext[SCORE_W] ? {SCORE_W{1'b1}} : sum_ext[SCORE_W-1:0];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        // Game end is taken one cycle after the capture that reached
        // MAX_ROLLS, from IDLE, before any new press is honoured.
        if (rolls == MAX_R)  state_nxt = OVER;
        else if (button)     state_nxt = ROLLING;
      end
      ROLLING: begin
        if (release_ev)      state_nxt = IDLE;
      end
      OVER: begin
        state_nxt = OVER;
      end
      default: state_nxt = IDLE;
    endcase
    if (new_game) state_nxt = button ? ROLLING : IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      button_q    <= 1'b0;
      score       <= '0;
      rolls       <= '0;
      last        <= 3'd0;
      double_flag <= 1'b0;
      roll_valid  <= 1'b0;
      bad_throw   <= 1'b0;
    end else begin
      state      <= state_nxt;
      button_q   <= button;
      roll_valid <= take_valid;
      bad_throw  <= take_bad;
      if (new_game) begin
        score       <= '0;
        rolls       <= '0;
        last        <= 3'd0;
        double_flag <= 1'b0;
      end else if (take_valid) begin
        score       <= score_sat;
        rolls       <= rolls + ROLL_W'(1);
        last        <= throw;
        double_flag <= (rolls != '0) && (throw == last);
      end
    end
  end

  // While rolling the face animates with the live dice value.
  assign face_val = (state == ROLLING) ? throw : last;

  dice_pips u_pips (
    .value (face_val),
    .pips  (pips)
  );

  assign game_over = (state == OVER);
  assign state_dbg = state;

endmodule
